uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of RX input synchronizer flops (minimum 2).
REQ-002 SHALL have port clock, input, 1, the single system clock (100 MHz).
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port uart_en, input, 1, receiver enable.
REQ-005 SHALL have port baud_rx_sel, input, 3, baud select.
REQ-006 SHALL have port RX, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port rx_read, input, 1, one-cycle pulse acknowledging data_out.
REQ-008 SHALL have port data_out, output, 8, last good received byte.
REQ-009 SHALL have port rx_valid, output, 1, unread byte present in data_out.
REQ-010 SHALL have port rx_done, output, 1, one-cycle pulse per good frame.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-012 SHALL have port overrun, output, 1, sticky flag for a byte lost while rx_valid=1.

Function
REQ-013 SHALL pass RX through SYNC_STAGES flops, each reset to 1; all decisions use the synchronized value rxs.
REQ-014 SHALL map baud_rx_sel to bit count N: 000=10416, 001=5208, 010=2604, 011=1736, 100=868, 101=434, 110=217, 111=108; bit period = N+1 clocks.
REQ-015 SHALL latch N at start detection; baud_rx_sel changes mid-frame do not affect the current frame.
REQ-016 SHALL implement states IDLE, START, DATA, STOP with a 14-bit baud counter cleared on every state entry.
REQ-017 IDLE -> START when uart_en=1 and rxs=0.
REQ-018 START: counter counts up to N>>1 (mid start bit); at that point rxs=0 -> DATA, rxs=1 -> IDLE (false start, no flags).
REQ-019 DATA: counter counts 0..N, wraps to 0; at count N samples rxs into bit data_cnt, LSB first, data_cnt 0..7; after bit 7 -> STOP, data_cnt=0.
REQ-020 STOP: at count N samples rxs, then -> IDLE immediately (mid stop bit), so a start bit that follows directly is caught.
REQ-021 Stop sample 1: the next cycle sets data_out=shift byte, rx_valid=1, and rx_done high for exactly one clock.
REQ-022 Stop sample 0: the next cycle sets frame_err high for one clock; data_out, rx_valid and rx_done stay unchanged.
REQ-023 Good frame while rx_valid=1 and rx_read not high that cycle: overrun=1 (sticky), data_out overwritten, rx_valid stays 1.
REQ-024 rx_read=1 clears rx_valid and overrun next cycle; rx_read together with a completing good frame gives rx_valid=1 and overrun unchanged.
REQ-025 uart_en=0 in any state forces IDLE next cycle, clears counter and data_cnt, and suppresses rx_done and frame_err; data_out, rx_valid and overrun hold.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 resetn=0 asynchronously SHALL set state=IDLE, counter=0, data_cnt=0, synchronizer flops=1, data_out=8'h00, rx_valid=0, rx_done=0, frame_err=0, overrun=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no pulse; reception resumes on the first falling edge after release.

Verification
REQ-029 sel=111 (109-clock bits), uart_en=1, frame 0x55 (start, 10101010 LSB-first, stop=1) -> one rx_done pulse, data_out=8'h55, rx_valid=1, frame_err=0.
REQ-030 sel=111, RX low for 40 clocks then high -> no state beyond START, no rx_done or frame_err, rx_valid stays 0.
REQ-031 sel=100, frame 0xA3 with stop bit 0 -> frame_err one-clock pulse, rx_done=0, data_out keeps its prior value.
REQ-032 Two back-to-back frames 0x12 then 0x34, rx_read never asserted -> second rx_done, data_out=8'h34, overrun=1; rx_read pulse -> rx_valid=0, overrun=0.
REQ-033 resetn low during DATA bit 3 of frame 0xFF, then a clean 0x0F frame -> outputs at reset values, then data_out=8'h0F with a single rx_done.
REQ-034 baud_rx_sel changed 111->000 during DATA of 0xC6 at 111 timing -> byte received as 8'hC6; next frame decoded at 10417-clock bits.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, run-time baud select, mid-bit sampling,
// registered status outputs with read-acknowledge and sticky overrun.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge on the synchronized RX
// START | timing to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; leave at mid stop bit to catch next start

module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       uart_en,
    input  logic [2:0] baud_rx_sel,
    input  logic       RX,
    input  logic       rx_read,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_done,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state, state_d;
    logic [13:0]            cnt, cnt_d;
    logic [13:0]            n_lat, n_d;
    logic [2:0]             bit_cnt, bit_d;
    logic [7:0]             shift, shift_d;
    logic                   frame_good, frame_bad;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    // Bit period is N+1 clocks at 100 MHz.
    function automatic logic [13:0] baud_n(input logic [2:0] sel);
        case (sel)
            3'b000:  baud_n = 14'd10416;
            3'b001:  baud_n = 14'd5208;
            3'b010:  baud_n = 14'd2604;
            3'b011:  baud_n = 14'd1736;
            3'b100:  baud_n = 14'd868;
            3'b101:  baud_n = 14'd434;
            3'b110:  baud_n = 14'd217;
            default: baud_n = 14'd108;
        endcase
    endfunction

    // RX synchronizer; resets to the idle-high line level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
        end else if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
        end else begin
            sync_q <= {SYNC_STAGES{RX}};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // FSM state and datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            n_lat   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            n_lat   <= n_d;
            bit_cnt <= bit_d;
            shift   <= shift_d;
        end
    end

    // Next-state, counter and bit-sampling decisions.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 14'd1;
        n_d        = n_lat;
        bit_d      = bit_cnt;
        shift_d    = shift;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rxs) begin
                    state_d = START;
                    n_d     = baud_n(baud_rx_sel);
                end
            end
            START: begin
                if (cnt == (n_lat >> 1)) begin
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == n_lat) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == n_lat) begin
                    cnt_d      = '0;
                    state_d    = IDLE;
                    frame_good = rxs;
                    frame_bad  = !rxs;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!uart_en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            bit_d      = '0;
            frame_good = 1'b0;
            frame_bad  = 1'b0;
        end
    end

    // Registered status outputs; a completing frame wins over a read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out  <= 8'h00;
            rx_valid  <= 1'b0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= frame_bad;
            if (frame_good) begin
                data_out <= shift;
                rx_valid <= 1'b1;
                rx_done  <= 1'b1;
                if (rx_valid && !rx_read) begin
                    overrun <= 1'b1;
                end
            end else if (rx_read) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames, false start, framing error,
// overrun, mid-frame reset and mid-frame baud change.

module tb_uart_rx;

    logic       clock;
    logic       resetn;
    logic       uart_en;
    logic [2:0] baud_rx_sel;
    logic       RX;
    logic       rx_read;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_done;
    logic       frame_err;
    logic       overrun;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int exp_done = 0;
    int exp_ferr = 0;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .uart_en     (uart_en),
        .baud_rx_sel (baud_rx_sel),
        .RX          (RX),
        .rx_read     (rx_read),
        .data_out    (data_out),
        .rx_valid    (rx_valid),
        .rx_done     (rx_done),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count clocks with each pulse high; a one-clock pulse adds exactly one.
    always @(posedge clock) begin
        if (rx_done)   done_cnt <= done_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int clocks);
        RX = v;
        repeat (clocks) @(negedge clock);
    endtask

    // A bad stop bit is held low for only 3/4 bit so the low tail after the
    // mid-stop sample is shorter than half a bit and reads as a false start.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(b[i], p);
        if (stop_bit) begin
            drive_bit(1'b1, p);
        end else begin
            drive_bit(1'b0, (3 * p) / 4);
            drive_bit(1'b1, p);
        end
    endtask

    task automatic read_pulse();
        rx_read = 1'b1;
        @(negedge clock);
        rx_read = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        RX          = 1'b1;
        resetn      = 1'b0;
        uart_en     = 1'b1;
        baud_rx_sel = 3'b111;
        rx_read     = 1'b0;
        repeat (3) @(negedge clock);

        chk("reset data_out",  data_out,  8'h00);
        chk("reset rx_valid",  rx_valid,  1'b0);
        chk("reset rx_done",   rx_done,   1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset overrun",   overrun,   1'b0);
        resetn = 1'b1;
        repeat (5) @(negedge clock);

        // Good frame 0x55 at 109-clock bits
        send_frame(8'h55, 1'b1, 109);
        exp_done++;
        chk("f55 rx_done count", done_cnt, exp_done);
        chk("f55 data_out",      data_out, 8'h55);
        chk("f55 rx_valid",      rx_valid, 1'b1);
        chk("f55 frame_err cnt", ferr_cnt, exp_ferr);
        chk("f55 overrun",       overrun,  1'b0);
        read_pulse();
        chk("read clears valid", rx_valid, 1'b0);

        // False start: 40 clocks low is shorter than half of a 109-clock bit
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 300);
        chk("false start rx_done",   done_cnt, exp_done);
        chk("false start frame_err", ferr_cnt, exp_ferr);
        chk("false start rx_valid",  rx_valid, 1'b0);

        // Framing error: 0xA3 at 869-clock bits with stop bit low
        baud_rx_sel = 3'b100;
        send_frame(8'hA3, 1'b0, 869);
        exp_ferr++;
        chk("ferr frame_err count", ferr_cnt, exp_ferr);
        chk("ferr rx_done count",   done_cnt, exp_done);
        chk("ferr data_out held",   data_out, 8'h55);
        chk("ferr rx_valid held",   rx_valid, 1'b0);

        // Back-to-back 0x12, 0x34 without reading
        baud_rx_sel = 3'b111;
        send_frame(8'h12, 1'b1, 109);
        exp_done++;
        chk("b2b first data_out", data_out, 8'h12);
        chk("b2b first overrun",  overrun,  1'b0);
        send_frame(8'h34, 1'b1, 109);
        exp_done++;
        chk("b2b rx_done count",  done_cnt, exp_done);
        chk("b2b data_out",       data_out, 8'h34);
        chk("b2b rx_valid",       rx_valid, 1'b1);
        chk("b2b overrun",        overrun,  1'b1);
        read_pulse();
        chk("b2b read rx_valid",  rx_valid, 1'b0);
        chk("b2b read overrun",   overrun,  1'b0);

        // Reset during data bit 3 of 0xFF, then a clean 0x0F
        drive_bit(1'b0, 109);
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 109);
        drive_bit(1'b1, 50);
        resetn = 1'b0;
        repeat (4) @(negedge clock);
        chk("midrst data_out", data_out, 8'h00);
        chk("midrst rx_valid", rx_valid, 1'b0);
        chk("midrst overrun",  overrun,  1'b0);
        resetn = 1'b1;
        drive_bit(1'b1, 200);
        chk("midrst no pulse", done_cnt, exp_done);
        send_frame(8'h0F, 1'b1, 109);
        exp_done++;
        chk("after rst rx_done count", done_cnt, exp_done);
        chk("after rst data_out",      data_out, 8'h0F);
        chk("after rst frame_err cnt", ferr_cnt, exp_ferr);
        read_pulse();

        // Baud select changes mid-frame; current frame keeps 109-clock bits
        drive_bit(1'b0, 109);
        for (int i = 0; i < 3; i++) drive_bit(bit'(8'hC6 >> i), 109);
        baud_rx_sel = 3'b000;
        for (int i = 3; i < 8; i++) drive_bit(bit'(8'hC6 >> i), 109);
        drive_bit(1'b1, 109);
        exp_done++;
        chk("baudchg rx_done count", done_cnt, exp_done);
        chk("baudchg data_out",      data_out, 8'hC6);
        chk("baudchg overrun",       overrun,  1'b0);
        read_pulse();

        // At 10417-clock bits a 5000-clock low is still a false start;
        // any shorter bit period would treat it as a real frame.
        drive_bit(1'b0, 5000);
        drive_bit(1'b1, 52000);
        chk("slow false start rx_done",   done_cnt, exp_done);
        chk("slow false start frame_err", ferr_cnt, exp_ferr);
        chk("slow false start rx_valid",  rx_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
